// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for the 4x4 output-stationary systolic multiplier array.
// Buffers operand matrices A and B, clears the array accumulators, then drives
// the skewed row/column wavefronts, waits for the pipeline to drain and pulses
// done_o. All outputs are registered from the next state and next count.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start_i; buffer writes accepted here only
// S_CLEAR | one cycle, array accumulators held in clear (array_rst_no=0)
// S_FEED  | cnt = t = 0..9, skewed operands presented on left/up edges
// S_DRAIN | DRAIN_CYC cycles of zero operands while the array settles
// S_DONE  | one cycle, done_o=1, results valid in the array

module systolic_feed_ctrl #(
  parameter int DW        = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic          wr_sel_i,
  input  logic [3:0]    wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          array_rst_no,
  output logic [DW-1:0] left_o_0,
  output logic [DW-1:0] left_o_1,
  output logic [DW-1:0] left_o_2,
  output logic [DW-1:0] left_o_3,
  output logic [DW-1:0] up_o_0,
  output logic [DW-1:0] up_o_1,
  output logic [DW-1:0] up_o_2,
  output logic [DW-1:0] up_o_3
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] FEED_LAST  = 4'd9;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [DW-1:0] a_buf [16];
  logic [DW-1:0] b_buf [16];

  logic [DW-1:0] left_q [4];
  logic [DW-1:0] up_q   [4];
  logic [DW-1:0] left_d [4];
  logic [DW-1:0] up_d   [4];

  logic          busy_q, done_q, arst_n_q;

  // State and cycle counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter sequencing; abort wins over normal progress
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (start_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = 4'd0;
      end
      S_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (abort_i && (state_q == S_CLEAR || state_q == S_FEED || state_q == S_DRAIN)) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end
  end

  // Operand selection for the upcoming cycle: row r sees A[r][t-r], column c sees B[t-c][c].
  // The 5-bit difference wraps negative offsets above 3, so one compare covers both bounds.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      left_d[i] = '0;
      up_d[i]   = '0;
    end
    if (state_d == S_FEED) begin
      for (int r = 0; r < 4; r++) begin
        if (({1'b0, cnt_d} - 5'(r)) < 5'd4)
          left_d[r] = a_buf[{2'(r), cnt_d[1:0] - 2'(r)}];
      end
      for (int c = 0; c < 4; c++) begin
        if (({1'b0, cnt_d} - 5'(c)) < 5'd4)
          up_d[c] = b_buf[{cnt_d[1:0] - 2'(c), 2'(c)}];
      end
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      arst_n_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        left_q[i] <= '0;
        up_q[i]   <= '0;
      end
    end else begin
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      arst_n_q <= (state_d != S_CLEAR);
      for (int i = 0; i < 4; i++) begin
        left_q[i] <= left_d[i];
        up_q[i]   <= up_d[i];
      end
    end
  end

  // Operand buffers; writes only land while idle so a run never sees a torn matrix
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else if (wr_en_i && state_q == S_IDLE) begin
      if (wr_sel_i) b_buf[wr_addr_i] <= wr_data_i;
      else          a_buf[wr_addr_i] <= wr_data_i;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign array_rst_no = arst_n_q;
  assign left_o_0     = left_q[0];
  assign left_o_1     = left_q[1];
  assign left_o_2     = left_q[2];
  assign left_o_3     = left_q[3];
  assign up_o_0       = up_q[0];
  assign up_o_1       = up_q[1];
  assign up_o_2       = up_q[2];
  assign up_o_3       = up_q[3];

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: the stimulus side pushes the
// expected per-cycle output picture of each run, a negedge monitor pops and
// compares whenever the controller is busy, and checks idle outputs otherwise.

module tb_systolic_feed_ctrl;

  localparam int DW = 32;
  localparam int DC = 2;
  localparam int N  = 12 + DC;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wr_en_i, wr_sel_i;
  logic [3:0]    wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          start_i, abort_i;
  logic          busy_o, done_o, array_rst_no;
  logic [DW-1:0] left_o_0, left_o_1, left_o_2, left_o_3;
  logic [DW-1:0] up_o_0, up_o_1, up_o_2, up_o_3;

  systolic_feed_ctrl #(.DW(DW), .DRAIN_CYC(DC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .array_rst_no(array_rst_no),
    .left_o_0(left_o_0), .left_o_1(left_o_1), .left_o_2(left_o_2), .left_o_3(left_o_3),
    .up_o_0(up_o_0), .up_o_1(up_o_1), .up_o_2(up_o_2), .up_o_3(up_o_3)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic                arst_n;
    logic [3:0][DW-1:0]  left;
    logic [3:0][DW-1:0]  up;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] ma[16];
  logic [DW-1:0] mb[16];
  int            checks   = 0;
  int            failures = 0;
  logic          rst_at_edge = 1'b1;

  always @(posedge clk_i) rst_at_edge = rst_i;

  // Expected outputs in cycle k after the accepting edge (1 = CLEAR .. N = DONE)
  function automatic exp_t make_exp(input int k);
    exp_t e;
    int   t;
    e        = '0;
    e.busy   = 1'b1;
    e.done   = (k == N);
    e.arst_n = (k != 1);
    if (k >= 2 && k <= 11) begin
      t = k - 2;
      for (int r = 0; r < 4; r++)
        if (t - r >= 0 && t - r <= 3) e.left[r] = ma[r * 4 + (t - r)];
      for (int c = 0; c < 4; c++)
        if (t - c >= 0 && t - c <= 3) e.up[c] = mb[(t - c) * 4 + c];
    end
    return e;
  endfunction

  // Monitor: compare against the scoreboard while busy, expect quiet outputs while idle
  always @(negedge clk_i) begin
    logic [3:0][DW-1:0] lv;
    logic [3:0][DW-1:0] uv;
    exp_t e;
    lv = {left_o_3, left_o_2, left_o_1, left_o_0};
    uv = {up_o_3, up_o_2, up_o_1, up_o_0};
    if (!rst_i) begin
      checks++;
      if (busy_o || done_o) begin
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_busy got busy=%0b done=%0b want idle", busy_o, done_o);
        end else begin
          e = expq.pop_front();
          if (busy_o !== e.busy || done_o !== e.done || array_rst_no !== e.arst_n ||
              lv !== e.left || uv !== e.up) begin
            failures++;
            $display("FAIL cycle_out got busy=%0b done=%0b arst_n=%0b left=%h up=%h want busy=%0b done=%0b arst_n=%0b left=%h up=%h",
                     busy_o, done_o, array_rst_no, lv, uv, e.busy, e.done, e.arst_n, e.left, e.up);
          end
        end
      end else if (lv !== '0 || uv !== '0 || (!rst_at_edge && array_rst_no !== 1'b1)) begin
        failures++;
        $display("FAIL idle_out got arst_n=%0b left=%h up=%h want arst_n=1 all zero", array_rst_no, lv, uv);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_elem(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
    step();
    wr_en_i = 1'b0;
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout got busy=%0b want 0 within 60 cycles", busy_o);
    end
    step();
  endtask

  // Start a run from IDLE. cut_k>0 aborts (or resets, if do_rst) in cycle cut_k.
  // hold keeps start_i high through DONE so a second run follows after one IDLE cycle.
  task automatic start_run(input int cut_k, input bit do_rst, input bit hold);
    int n_push;
    start_i = 1'b1;
    step();
    if (!hold) start_i = 1'b0;
    n_push = (cut_k > 0) ? (do_rst ? cut_k - 1 : cut_k) : N;
    for (int k = 1; k <= n_push; k++) expq.push_back(make_exp(k));
    if (hold) begin
      for (int k = 1; k <= N; k++) expq.push_back(make_exp(k));
      repeat (N + 1) step();
      start_i = 1'b0;
    end
    if (cut_k > 0) begin
      repeat (cut_k - 1) step();
      if (do_rst) begin
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || array_rst_no !== 1'b0 ||
            {left_o_0, left_o_1, left_o_2, left_o_3, up_o_0, up_o_1, up_o_2, up_o_3} !== '0) begin
          failures++;
          $display("FAIL reset_mid_run got busy=%0b done=%0b arst_n=%0b left0=%h up0=%h want all 0",
                   busy_o, done_o, array_rst_no, left_o_0, up_o_0);
        end
        for (int i = 0; i < 16; i++) begin
          ma[i] = '0;
          mb[i] = '0;
        end
        step();
        rst_i = 1'b0;
      end else begin
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
          failures++;
          $display("FAIL abort_idle got busy=%0b done=%0b want busy=0 done=0", busy_o, done_o);
        end
      end
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000ns");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_sel_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    start_i = 1'b0; abort_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    #2;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || array_rst_no !== 1'b0 ||
        {left_o_0, left_o_1, left_o_2, left_o_3, up_o_0, up_o_1, up_o_2, up_o_3} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%0b done=%0b arst_n=%0b want 0 0 0 and zero operands",
               busy_o, done_o, array_rst_no);
    end
    repeat (2) step();
    rst_i = 1'b0;
    repeat (2) step();

    // Identity A, B[i][j] = 4i+j+1
    for (int i = 0; i < 16; i++) begin
      write_elem(1'b0, 4'(i), (i / 4 == i % 4) ? 32'd1 : 32'd0);
      write_elem(1'b1, 4'(i), 32'(i + 1));
    end
    start_run(0, 1'b0, 1'b0);

    // Skew pattern
    for (int i = 0; i < 16; i++) begin
      write_elem(1'b0, 4'(i), 32'(16 + i));
      write_elem(1'b1, 4'(i), 32'(256 + i));
    end
    start_run(0, 1'b0, 1'b0);

    // Write during FEED must be dropped; rerun feeds the original A[0][0]
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= N; k++) expq.push_back(make_exp(k));
    repeat (3) step();
    wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_addr_i = 4'd0; wr_data_i = 32'd7;
    step();
    wr_en_i = 1'b0;
    wait_idle();
    start_run(0, 1'b0, 1'b0);

    // Write B[3][3]=9 together with start
    wr_en_i = 1'b1; wr_sel_i = 1'b1; wr_addr_i = 4'd15; wr_data_i = 32'd9;
    mb[15] = 32'd9;
    start_i = 1'b1;
    step();
    wr_en_i = 1'b0;
    start_i = 1'b0;
    for (int k = 1; k <= N; k++) expq.push_back(make_exp(k));
    wait_idle();

    // Abort at FEED t=4, then a normal run
    start_run(6, 1'b0, 1'b0);
    start_run(0, 1'b0, 1'b0);

    // start_i held through DONE gives back-to-back runs with one IDLE gap
    start_run(0, 1'b0, 1'b1);

    // Reset in the first DRAIN cycle, then a run over the cleared buffers
    start_run(12, 1'b1, 1'b0);
    wait_idle();
    start_run(0, 1'b0, 1'b0);

    // Randomized loads and runs
    for (int it = 0; it < 12; it++) begin
      int nw;
      int kind;
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++)
        write_elem(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      kind = $urandom_range(0, 2);
      if (kind == 0)      start_run(0, 1'b0, 1'b0);
      else if (kind == 1) start_run($urandom_range(1, N - 1), 1'b0, 1'b0);
      else                start_run(0, 1'b0, 1'b1);
    end

    repeat (2) step();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
